vga_clock_render: RTL and testbench

- Pixel-generation stage directly downstream of the 1440x900 VGA timing generator.
- Consumes its hsync/vsync/valid and h/v pixel counters. Draws a six-digit HH:MM:SS seven-segment clock face with two colons at a fixed screen position.
- Emits 12-bit RGB plus delayed syncs to the VGA output pins.
- Time arrives as packed BCD from the clock-core; updates are applied only at frame start to avoid tearing.

---
 rtl/vga_clock_render_if.sv | 26 ++
 rtl/vga_clock_render.sv | 211 +++++++++++++++++++++
 tb/tb_vga_clock_render.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_clock_render_if.sv
// Pixel-stream bundle between the VGA timing generator, the clock renderer
// and the output pins, plus the packed-BCD time feed from the clock core.
interface vga_clock_render_if;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_valid;
  logic [11:0] vga_h_cnt;
  logic [10:0] vga_v_cnt;
  logic [23:0] time_bcd;
  logic        time_vld;
  logic [11:0] vga_rgb;
  logic        vga_hsync_o;
  logic        vga_vsync_o;

  modport master (
    output vga_hsync, vga_vsync, vga_valid, vga_h_cnt, vga_v_cnt,
    output time_bcd, time_vld,
    input  vga_rgb, vga_hsync_o, vga_vsync_o
  );

  modport slave (
    input  vga_hsync, vga_vsync, vga_valid, vga_h_cnt, vga_v_cnt,
    input  time_bcd, time_vld,
    output vga_rgb, vga_hsync_o, vga_vsync_o
  );
endinterface

// File: rtl/vga_clock_render.sv
// Two-stage pixel pipeline drawing an HH:MM:SS seven-segment clock face.
// Optional colon blinking is built when VGA_CLOCK_COLON_BLINK_EN is defined.
module vga_clock_render #(
  parameter int unsigned X0           = 320,
  parameter int unsigned Y0           = 370,
  parameter int unsigned DW           = 64,
  parameter int unsigned DH           = 128,
  parameter int unsigned T            = 12,
  parameter int unsigned GAP          = 32,
  parameter logic [11:0] FG           = 12'hFFF,
  parameter logic [11:0] BG           = 12'h000,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic               vga_pclk,
  input  logic               vga_rst_n,
  vga_clock_render_if.slave  bus
);

  localparam int unsigned CW = DW + GAP;

  localparam logic [6:0] LX_T   = 7'(T);
  localparam logic [6:0] LX_R   = 7'(DW - T);
  localparam logic [6:0] LX_CL  = 7'(DW / 2 - T);
  localparam logic [6:0] LX_CH  = 7'(DW / 2 + T);
  localparam logic [7:0] LY_T   = 8'(T);
  localparam logic [7:0] LY_D   = 8'(DH - T);
  localparam logic [7:0] LY_GL  = 8'(DH / 2 - T / 2);
  localparam logic [7:0] LY_GH  = 8'(DH / 2 + T / 2);
  localparam logic [7:0] LY_MID = 8'(DH / 2);
  localparam logic [7:0] LY_C1L = 8'(DH / 4 - T);
  localparam logic [7:0] LY_C1H = 8'(DH / 4 + T);
  localparam logic [7:0] LY_C2L = 8'(3 * DH / 4 - T);
  localparam logic [7:0] LY_C2H = 8'(3 * DH / 4 + T);

  // Segment mask order {a,b,c,d,e,f,g}; non-decimal nibbles stay dark.
  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    logic [6:0] p;
    p = '0;
    case (d)
      4'd0: p = 7'b1111110;
      4'd1: p = 7'b0110000;
      4'd2: p = 7'b1101101;
      4'd3: p = 7'b1111001;
      4'd4: p = 7'b0110011;
      4'd5: p = 7'b1011011;
      4'd6: p = 7'b1011111;
      4'd7: p = 7'b1110000;
      4'd8: p = 7'b1111111;
      4'd9: p = 7'b1111011;
      default: p = '0;
    endcase
    return p;
  endfunction

  // ---------------- time capture ----------------
  logic        r_vsync_prev;
  logic [23:0] r_shadow;
  logic [23:0] r_active;
  logic        w_frame_start;
  logic        w_colon_on;

  assign w_frame_start = ~bus.vga_vsync & r_vsync_prev;

  // A strobe on the frame-start cycle bypasses the shadow so it is not lost for a frame.
  always_ff @(posedge vga_pclk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_vsync_prev <= 1'b1;
      r_shadow     <= '0;
      r_active     <= '0;
    end else begin
      r_vsync_prev <= bus.vga_vsync;
      if (bus.time_vld)
        r_shadow <= bus.time_bcd;
      if (w_frame_start)
        r_active <= bus.time_vld ? bus.time_bcd : r_shadow;
    end
  end

`ifdef VGA_CLOCK_COLON_BLINK_EN
  localparam int unsigned      FCW     = $clog2(2 * BLINK_FRAMES);
  localparam logic [FCW-1:0]   FC_LAST = FCW'(2 * BLINK_FRAMES - 1);
  localparam logic [FCW-1:0]   FC_HALF = FCW'(BLINK_FRAMES);

  logic [FCW-1:0] r_frame_cnt;

  always_ff @(posedge vga_pclk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_frame_cnt <= '0;
    end else if (w_frame_start) begin
      r_frame_cnt <= (r_frame_cnt == FC_LAST) ? '0 : r_frame_cnt + 1'b1;
    end
  end

  assign w_colon_on = (r_frame_cnt < FC_HALF);
`else
  assign w_colon_on = 1'b1;
`endif

  // ---------------- stage 1: cell locate ----------------
  logic [31:0] w_h32;
  logic [31:0] w_v32;
  logic        w_in_rows;
  logic [3:0]  w_cell;
  logic [6:0]  w_lx;
  logic [7:0]  w_ly;

  assign w_h32 = 32'(bus.vga_h_cnt);
  assign w_v32 = 32'(bus.vga_v_cnt);

  always_comb begin
    w_cell    = 4'd8;
    w_lx      = '0;
    w_in_rows = (w_v32 >= Y0) && (w_v32 < Y0 + DH);
    w_ly      = 8'(w_v32 - Y0);
    for (int unsigned k = 0; k < 8; k++) begin
      if (w_in_rows && (w_h32 >= X0 + k * CW) && (w_h32 < X0 + k * CW + DW)) begin
        w_cell = 4'(k);
        w_lx   = 7'(w_h32 - (X0 + k * CW));
      end
    end
  end

  logic [3:0] r_s1_cell;
  logic [6:0] r_s1_lx;
  logic [7:0] r_s1_ly;
  logic       r_s1_valid;
  logic       r_s1_hsync;
  logic       r_s1_vsync;

  always_ff @(posedge vga_pclk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_s1_cell  <= 4'd8;
      r_s1_lx    <= '0;
      r_s1_ly    <= '0;
      r_s1_valid <= 1'b0;
      r_s1_hsync <= 1'b1;
      r_s1_vsync <= 1'b1;
    end else begin
      r_s1_cell  <= w_cell;
      r_s1_lx    <= w_lx;
      r_s1_ly    <= w_ly;
      r_s1_valid <= bus.vga_valid;
      r_s1_hsync <= bus.vga_hsync;
      r_s1_vsync <= bus.vga_vsync;
    end
  end

  // ---------------- stage 2: segment hit and colour ----------------
  logic [3:0] w_digit;
  logic       w_is_digit;
  logic       w_is_colon;
  logic       w_mid;
  logic [6:0] w_seg_area;
  logic       w_colon_area;
  logic       w_hit;

  always_comb begin
    w_digit    = 4'hF;
    w_is_digit = 1'b0;
    w_is_colon = 1'b0;
    case (r_s1_cell)
      4'd0: begin w_digit = r_active[23:20]; w_is_digit = 1'b1; end
      4'd1: begin w_digit = r_active[19:16]; w_is_digit = 1'b1; end
      4'd2: w_is_colon = 1'b1;
      4'd3: begin w_digit = r_active[15:12]; w_is_digit = 1'b1; end
      4'd4: begin w_digit = r_active[11:8];  w_is_digit = 1'b1; end
      4'd5: w_is_colon = 1'b1;
      4'd6: begin w_digit = r_active[7:4];   w_is_digit = 1'b1; end
      4'd7: begin w_digit = r_active[3:0];   w_is_digit = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    w_mid         = (r_s1_lx >= LX_T) && (r_s1_lx < LX_R);
    w_seg_area    = '0;
    w_seg_area[6] = (r_s1_ly < LY_T) && w_mid;                              // a
    w_seg_area[5] = (r_s1_lx >= LX_R) && (r_s1_ly < LY_MID);                // b
    w_seg_area[4] = (r_s1_lx >= LX_R) && (r_s1_ly >= LY_MID);               // c
    w_seg_area[3] = (r_s1_ly >= LY_D) && w_mid;                             // d
    w_seg_area[2] = (r_s1_lx < LX_T) && (r_s1_ly >= LY_MID);                // e
    w_seg_area[1] = (r_s1_lx < LX_T) && (r_s1_ly < LY_MID);                 // f
    w_seg_area[0] = (r_s1_ly >= LY_GL) && (r_s1_ly < LY_GH) && w_mid;       // g
    w_colon_area  = (r_s1_lx >= LX_CL) && (r_s1_lx < LX_CH) &&
                    (((r_s1_ly >= LY_C1L) && (r_s1_ly < LY_C1H)) ||
                     ((r_s1_ly >= LY_C2L) && (r_s1_ly < LY_C2H)));
    w_hit         = (w_is_digit && (|(seg_pattern(w_digit) & w_seg_area))) ||
                    (w_is_colon && w_colon_area && w_colon_on);
  end

  logic [11:0] r_rgb;
  logic        r_hsync_o;
  logic        r_vsync_o;

  always_ff @(posedge vga_pclk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_rgb     <= '0;
      r_hsync_o <= 1'b1;
      r_vsync_o <= 1'b1;
    end else begin
      r_rgb     <= r_s1_valid ? (w_hit ? FG : BG) : '0;
      r_hsync_o <= r_s1_hsync;
      r_vsync_o <= r_s1_vsync;
    end
  end

  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hsync_o = r_hsync_o;
  assign bus.vga_vsync_o = r_vsync_o;

endmodule

// File: tb/tb_vga_clock_render.sv
// Self-checking bench for vga_clock_render: directed vector table, hand-written
// tear/reset/blink sequences and randomized pixels against a reference model.
`timescale 1ns/1ps
module tb_vga_clock_render;

  localparam logic [11:0] FG = 12'hFFF;
  localparam logic [11:0] BG = 12'h000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  vga_clock_render_if bus ();

  vga_clock_render dut (
    .vga_pclk  (clk),
    .vga_rst_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
    bit          tbl;
    logic [11:0] tbl_rgb;
    string       nm;
  } exp_t;

  typedef struct {
    logic [23:0] t;
    bit          bypass;
    int unsigned h;
    int unsigned v;
    logic [11:0] rgb;
    string       nm;
  } vec_t;

  exp_t        q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  logic [23:0] m_shadow;
  logic [23:0] m_active;
  logic        m_prev_vs;
  int unsigned m_fc;

  string SEGS [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  function automatic bit seg_on(input int unsigned d, input string s);
    if (d > 9) return 1'b0;
    for (int i = 0; i < SEGS[d].len(); i++)
      if (SEGS[d][i] == s[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit colon_on();
`ifdef VGA_CLOCK_COLON_BLINK_EN
    return (m_fc < 30);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [11:0] model_pixel(input int unsigned h, input int unsigned v,
                                              input logic [23:0] t, input bit con);
    int unsigned k, lx, ly, pos, d;
    bit hit, mid;
    if (v < 370 || v >= 498 || h < 320) return BG;
    k  = (h - 320) / 96;
    lx = (h - 320) % 96;
    ly = v - 370;
    if (k > 7 || lx >= 64) return BG;
    if (k == 2 || k == 5) begin
      hit = con && lx >= 20 && lx < 44 && ((ly >= 20 && ly < 44) || (ly >= 84 && ly < 108));
    end else begin
      pos = k - ((k > 2) ? 1 : 0) - ((k > 5) ? 1 : 0);
      d   = int'((t >> (20 - 4 * pos)) & 24'hF);
      mid = lx >= 12 && lx < 52;
      hit = (seg_on(d, "a") && ly < 12 && mid) ||
            (seg_on(d, "d") && ly >= 116 && mid) ||
            (seg_on(d, "g") && ly >= 58 && ly < 70 && mid) ||
            (seg_on(d, "f") && lx < 12 && ly < 64) ||
            (seg_on(d, "b") && lx >= 52 && ly < 64) ||
            (seg_on(d, "e") && lx < 12 && ly >= 64) ||
            (seg_on(d, "c") && lx >= 52 && ly >= 64);
    end
    return hit ? FG : BG;
  endfunction

  task automatic chk(input bit ok, input string msg);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s", msg);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk(bus.vga_rgb === 12'h000 && bus.vga_hsync_o === 1'b1 && bus.vga_vsync_o === 1'b1,
        $sformatf("%s: got rgb=%h hs=%b vs=%b, required rgb=000 hs=1 vs=1",
                  nm, bus.vga_rgb, bus.vga_hsync_o, bus.vga_vsync_o));
  endtask

  task automatic model_reset();
    exp_t e;
    m_shadow  = '0;
    m_active  = '0;
    m_prev_vs = 1'b1;
    m_fc      = 0;
    q.delete();
    e.rgb = 12'h000; e.hs = 1'b1; e.vs = 1'b1; e.tbl = 1'b0; e.tbl_rgb = '0; e.nm = "";
    q.push_back(e);
  endtask

  task automatic step(input int unsigned h, input int unsigned v, input bit vld,
                      input bit hs, input bit vs, input bit tv, input logic [23:0] t,
                      input bit tbl, input logic [11:0] trgb, input string nm);
    exp_t e, o;
    bit   fs;
    bus.vga_h_cnt = 12'(h);
    bus.vga_v_cnt = 11'(v);
    bus.vga_valid = vld;
    bus.vga_hsync = hs;
    bus.vga_vsync = vs;
    bus.time_vld  = tv;
    bus.time_bcd  = t;
    fs = !vs && m_prev_vs;
    m_prev_vs = vs;
    if (fs) begin
      m_active = tv ? t : m_shadow;
      m_fc     = (m_fc + 1) % 60;
    end
    if (tv) m_shadow = t;
    e.rgb = vld ? model_pixel(h, v, m_active, colon_on()) : 12'h000;
    e.hs = hs; e.vs = vs; e.tbl = tbl; e.tbl_rgb = trgb; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
    o = q.pop_front();
    chk(bus.vga_rgb === o.rgb && bus.vga_hsync_o === o.hs && bus.vga_vsync_o === o.vs,
        $sformatf("pipe: got rgb=%h hs=%b vs=%b, required rgb=%h hs=%b vs=%b",
                  bus.vga_rgb, bus.vga_hsync_o, bus.vga_vsync_o, o.rgb, o.hs, o.vs));
    if (o.tbl)
      chk(bus.vga_rgb === o.tbl_rgb,
          $sformatf("%s: got rgb=%h, required %h", o.nm, bus.vga_rgb, o.tbl_rgb));
  endtask

  task automatic idle();
    step(0, 0, 0, 1, 1, 0, '0, 0, '0, "");
  endtask

  task automatic px(input int unsigned h, input int unsigned v, input bit tbl,
                    input logic [11:0] trgb, input string nm);
    step(h, v, 1, 1, 1, 0, '0, tbl, trgb, nm);
  endtask

  task automatic load(input logic [23:0] t);
    step(0, 0, 0, 1, 1, 1, t, 0, '0, "");
  endtask

  task automatic vpulse(input bit tv, input logic [23:0] t);
    step(0, 0, 0, 1, 0, tv, t, 0, '0, "");
    step(0, 0, 0, 0, 0, 0, '0, 0, '0, "");
    step(0, 0, 0, 1, 1, 0, '0, 0, '0, "");
  endtask

  task automatic drive_idle_inputs();
    bus.vga_h_cnt = '0; bus.vga_v_cnt = '0; bus.vga_valid = 1'b0;
    bus.vga_hsync = 1'b1; bus.vga_vsync = 1'b1; bus.time_vld = 1'b0; bus.time_bcd = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    repeat (3) begin
      @(posedge clk);
      #1;
      chk_reset_vals("reset hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t vecs[$];
  logic [11:0] exp_c;

  initial begin
    drive_idle_inputs();
    vecs = '{
      '{24'h123456, 1'b0, 380, 400, FG, "H1=1 seg b"},
      '{24'h123456, 1'b1, 350, 375, BG, "H1=1 no seg a"},
      '{24'h888888, 1'b0, 340, 375, FG, "8 seg a"},
      '{24'h888888, 1'b1, 325, 400, FG, "8 seg f"},
      '{24'h888888, 1'b0, 446, 430, FG, "8 seg g cell1"},
      '{24'h888888, 1'b1, 340, 497, FG, "8 seg d last line"},
      '{24'h888888, 1'b0, 340, 498, BG, "below face"},
      '{24'h888888, 1'b1, 340, 369, BG, "above face"},
      '{24'h888888, 1'b0, 390, 400, BG, "gap after cell0"},
      '{24'h888888, 1'b1, 606, 435, BG, "gap before cell3"},
      '{24'h1A3456, 1'b1, 446, 430, BG, "nibble A blank g"},
      '{24'h1A3456, 1'b0, 420, 380, BG, "nibble A blank f"},
      '{24'h235959, 1'b1, 926, 375, FG, "S1=5 seg a"},
      '{24'h235959, 1'b0, 1000, 470, BG, "S0=9 no seg e"},
      '{24'h235959, 1'b1, 544, 402, FG, "colon upper dot"},
      '{24'h000000, 1'b0, 100, 400, BG, "left of face"},
      '{24'h000000, 1'b1, 1060, 450, BG, "right of face"}
    };

    // Vector table: each entry loads a time (via shadow or bypass) and probes one pixel.
    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].bypass) begin
        vpulse(1, vecs[i].t);
      end else begin
        load(vecs[i].t);
        vpulse(0, '0);
      end
      px(vecs[i].h, vecs[i].v, 1, vecs[i].rgb, vecs[i].nm);
      idle();
    end

    // Tear-free update: a mid-frame load must not show until the next frame start.
    do_reset();
    vpulse(1, 24'h500000);
    px(380, 400, 1, BG, "H1=5 no seg b");
    px(350, 375, 1, FG, "H1=5 seg a");
    load(24'h123456);
    px(380, 400, 1, BG, "torn seg b held");
    px(350, 375, 1, FG, "torn seg a held");
    idle();
    vpulse(0, '0);
    px(380, 400, 1, FG, "updated seg b");
    px(350, 375, 1, BG, "updated seg a");
    idle();

    // Hsync delay with a single-cycle low pulse.
    step(0, 0, 0, 0, 1, 0, '0, 0, '0, "");
    idle();
    idle();

    // Reset mid-frame while showing 12:34:56.
    vpulse(1, 24'h123456);
    px(446, 430, 1, FG, "pre-reset H0=2 seg g");
    px(480, 400, 1, BG, "pre-reset gap");
    bus.vga_h_cnt = 12'd500;
    bus.vga_v_cnt = 11'd400;
    bus.vga_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset");
    do_reset();
    px(446, 430, 1, BG, "post-reset H0=0 seg g");
    vpulse(0, '0);
    px(446, 430, 1, BG, "post-reset frame seg g");
    px(380, 400, 1, FG, "post-reset H1=0 seg b");
    idle();

    // Colon blink over 61 frames from reset.
    do_reset();
    for (int f = 0; f <= 60; f++) begin
`ifdef VGA_CLOCK_COLON_BLINK_EN
      exp_c = ((f % 60) < 30) ? FG : BG;
`else
      exp_c = FG;
`endif
      px(544, 402, 1, exp_c, $sformatf("colon frame %0d", f));
      vpulse(0, '0);
    end

    // Randomized frames against the reference model.
    for (int fr = 0; fr < 15; fr++) begin
      vpulse($urandom_range(0, 1) == 1, 24'($urandom));
      for (int c = 0; c < 150; c++) begin
        if ($urandom_range(0, 7) != 0)
          step($urandom_range(300, 1080), $urandom_range(360, 510), 1,
               $urandom_range(0, 9) != 0, 1, $urandom_range(0, 30) == 0,
               24'($urandom), 0, '0, "");
        else
          step(0, 0, 0, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 30) == 0,
               24'($urandom), 0, '0, "");
      end
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
